// File: rtl/fb_write_queue.sv
// fb_write_queue: buffers (x, y, palette index) pixel writes from the display
// processor and drains them to the framebuffer RAM write port whenever
// fb_grant says the port is free. (x, y) becomes the linear address
// y*RESOLUTION_X + x when the pixel is pushed.
//
// Optional feature macro: FB_CLIP_EN
//   defined   - requests with in_x >= RESOLUTION_X or in_y >= RESOLUTION_Y are
//               discarded at the input. They bump drop_count but not overflow.
//   undefined - no range check. The address wraps modulo 2^AW.
module fb_write_queue #(
  parameter int RESOLUTION_X   = 400,
  parameter int RESOLUTION_Y   = 300,
  parameter int PALETTE_LENGTH = 256,
  parameter int DEPTH          = 16,
  localparam int XW = $clog2(RESOLUTION_X),
  localparam int YW = $clog2(RESOLUTION_Y),
  localparam int IW = $clog2(PALETTE_LENGTH),
  localparam int AW = $clog2(RESOLUTION_X * RESOLUTION_Y),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [XW-1:0] in_x,
  input  logic [YW-1:0] in_y,
  input  logic [IW-1:0] in_index,
  input  logic          in_wr_en,
  output logic          in_full,
  input  logic          fb_grant,
  output logic [AW-1:0] fb_addr,
  output logic [IW-1:0] fb_data,
  output logic          fb_wr_en,
  output logic [CW-1:0] level,
  output logic          overflow,
  output logic [15:0]   drop_count
);

  localparam int PW = CW - 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  entry_t        in_entry;
  logic          in_range;
  logic          pop;
  logic          push;
  logic          drop_full;
  logic          drop_clip;

  // Linear address: the product is formed at AW bits, then x is added, so
  // out-of-range coordinates wrap modulo 2^AW instead of widening.
  assign in_entry.addr = AW'(in_y) * AW'(RESOLUTION_X) + AW'(in_x);
  assign in_entry.data = in_index;

`ifdef FB_CLIP_EN
  localparam logic [XW:0] X_LIMIT = (XW + 1)'(RESOLUTION_X);
  localparam logic [YW:0] Y_LIMIT = (YW + 1)'(RESOLUTION_Y);
  assign in_range = ({1'b0, in_x} < X_LIMIT) && ({1'b0, in_y} < Y_LIMIT);
`else
  assign in_range = 1'b1;
`endif

  // Full status looks at occupancy only, never at fb_grant. A full queue
  // still accepts a push in a cycle that also pops.
  assign in_full   = (level == CW'(DEPTH));
  assign pop       = (level != '0) && fb_grant;
  assign push      = in_wr_en && in_range && (!in_full || pop);
  assign drop_full = in_wr_en && in_range && in_full && !pop;
  assign drop_clip = in_wr_en && !in_range;

  // Storage array: written on push, read at the head on pop.
  // NOTE: the entry array has no reset. Every slot is written before it can be
  // read, so resetting it would only add wiring and block RAM inference.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  // Pointers, occupancy, output register and drop statistics.
  // NOTE: all state here uses non-blocking assignments. The head read and the
  // write into the same slot on a full push+pop edge therefore see the old
  // contents.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      fb_wr_en   <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      fb_wr_en <= pop;
      if (pop) begin
        fb_addr <= mem[rd_ptr].addr;
        fb_data <= mem[rd_ptr].data;
        rd_ptr  <= rd_ptr + PW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + CW'(1);
        2'b01:   level <= level - CW'(1);
        default: level <= level;
      endcase
      if (drop_full) begin
        overflow <= 1'b1;
      end
      if ((drop_full || drop_clip) && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_queue.sv
// Directed self-checking bench for fb_write_queue (default geometry 400x300,
// 256-entry palette, 16-deep queue). Define FB_CLIP_EN for both the design and
// the bench to exercise the clipping build.
module tb_fb_write_queue;

  logic        clk;
  logic        reset_n;
  logic [8:0]  in_x;
  logic [8:0]  in_y;
  logic [7:0]  in_index;
  logic        in_wr_en;
  logic        in_full;
  logic        fb_grant;
  logic [16:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_wr_en;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_count;

  int errors = 0;
  int checks = 0;

  fb_write_queue dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_index   (in_index),
    .in_wr_en   (in_wr_en),
    .in_full    (in_full),
    .fb_grant   (fb_grant),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_wr_en   (fb_wr_en),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge. Outputs are sampled and inputs driven 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pixel(input logic en, input int x, input int y, input int idx);
    in_wr_en = en;
    in_x     = 9'(x);
    in_y     = 9'(y);
    in_index = 8'(idx);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    fb_grant = 1'b0;
    set_pixel(1'b0, 0, 0, 0);
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (level !== 5'd0)       begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (in_full !== 1'b0)     begin errors++; $display("FAIL reset_full got=%b exp=0", in_full); end
    checks++; if (fb_wr_en !== 1'b0)    begin errors++; $display("FAIL reset_wr_en got=%b exp=0", fb_wr_en); end
    checks++; if (fb_addr !== 17'd0)    begin errors++; $display("FAIL reset_addr got=%0d exp=0", fb_addr); end
    checks++; if (fb_data !== 8'd0)     begin errors++; $display("FAIL reset_data got=%0h exp=0", fb_data); end
    checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drops got=%0d exp=0", drop_count); end
  endtask

  // Pixel (3,2) -> 2*400+3 = 803, strobe two edges after the push.
  task automatic test_latency();
    do_reset();
    fb_grant = 1'b1;
    set_pixel(1'b1, 3, 2, 8'h5A);
    tick();
    set_pixel(1'b0, 0, 0, 0);
    checks++; if (fb_wr_en !== 1'b0) begin errors++; $display("FAIL lat_no_bypass got=%b exp=0", fb_wr_en); end
    checks++; if (level !== 5'd1)    begin errors++; $display("FAIL lat_level1 got=%0d exp=1", level); end
    tick();
    checks++; if (fb_wr_en !== 1'b1) begin errors++; $display("FAIL lat_wr_en got=%b exp=1", fb_wr_en); end
    checks++; if (fb_addr !== 17'd803) begin errors++; $display("FAIL lat_addr got=%0d exp=803", fb_addr); end
    checks++; if (fb_data !== 8'h5A) begin errors++; $display("FAIL lat_data got=%0h exp=5a", fb_data); end
    checks++; if (level !== 5'd0)    begin errors++; $display("FAIL lat_level0 got=%0d exp=0", level); end
    tick();
    checks++; if (fb_wr_en !== 1'b0)   begin errors++; $display("FAIL lat_idle got=%b exp=0", fb_wr_en); end
    checks++; if (fb_addr !== 17'd803) begin errors++; $display("FAIL lat_hold got=%0d exp=803", fb_addr); end
  endtask

  // Fill 16 pixels on row 1, drop a 17th, then drain in order.
  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_pixel(1'b1, i, 1, 8'h10 + i);
      tick();
    end
    checks++; if (level !== 5'd16)      begin errors++; $display("FAIL ovf_level got=%0d exp=16", level); end
    checks++; if (in_full !== 1'b1)     begin errors++; $display("FAIL ovf_full got=%b exp=1", in_full); end
    checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL ovf_early got=%b exp=0", overflow); end
    set_pixel(1'b1, 100, 0, 8'hFF);
    tick();
    set_pixel(1'b0, 0, 0, 0);
    checks++; if (overflow !== 1'b1)    begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL ovf_drops got=%0d exp=1", drop_count); end
    checks++; if (level !== 5'd16)      begin errors++; $display("FAIL ovf_level_kept got=%0d exp=16", level); end
    fb_grant = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (fb_wr_en !== 1'b1 || fb_addr !== 17'(400 + i) || fb_data !== 8'(8'h10 + i)) begin
        errors++;
        $display("FAIL drain_%0d got=wr%b addr%0d data%0h exp=wr1 addr%0d data%0h",
                 i, fb_wr_en, fb_addr, fb_data, 400 + i, 8'h10 + i);
      end
    end
    tick();
    checks++; if (fb_wr_en !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL drain_end got=wr%b lvl%0d exp=wr0 lvl0", fb_wr_en, level); end
    checks++; if (overflow !== 1'b1)    begin errors++; $display("FAIL ovf_still_sticky got=%b exp=1", overflow); end
  endtask

  // Full queue with grant and a write every cycle: no drops, FIFO order.
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_pixel(1'b1, i, 5, 8'h20 + i);
      tick();
    end
    fb_grant = 1'b1;
    for (int j = 0; j < 16; j++) begin
      set_pixel(1'b1, 50 + j, 6, 8'h40 + j);
      tick();
      checks++;
      if (fb_wr_en !== 1'b1 || fb_addr !== 17'(2000 + j) || fb_data !== 8'(8'h20 + j) || level !== 5'd16) begin
        errors++;
        $display("FAIL b2b_%0d got=wr%b addr%0d data%0h lvl%0d exp=wr1 addr%0d data%0h lvl16",
                 j, fb_wr_en, fb_addr, fb_data, level, 2000 + j, 8'h20 + j);
      end
    end
    set_pixel(1'b0, 0, 0, 0);
    for (int j = 0; j < 16; j++) begin
      tick();
      checks++;
      if (fb_wr_en !== 1'b1 || fb_addr !== 17'(2450 + j) || fb_data !== 8'(8'h40 + j)) begin
        errors++;
        $display("FAIL b2b_tail_%0d got=wr%b addr%0d data%0h exp=wr1 addr%0d data%0h",
                 j, fb_wr_en, fb_addr, fb_data, 2450 + j, 8'h40 + j);
      end
    end
    checks++; if (drop_count !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL b2b_drops got=%0d/%b exp=0/0", drop_count, overflow); end
  endtask

  // Extreme coordinates: (399,299) -> 119999, (0,0) -> 0.
  task automatic test_corners();
    do_reset();
    fb_grant = 1'b1;
    set_pixel(1'b1, 399, 299, 8'h11);
    tick();
    set_pixel(1'b1, 0, 0, 8'h22);
    tick();
    set_pixel(1'b0, 0, 0, 0);
    checks++; if (fb_wr_en !== 1'b1 || fb_addr !== 17'd119999 || fb_data !== 8'h11) begin errors++; $display("FAIL corner_max got=wr%b addr%0d data%0h exp=wr1 addr119999 data11", fb_wr_en, fb_addr, fb_data); end
    tick();
    checks++; if (fb_wr_en !== 1'b1 || fb_addr !== 17'd0 || fb_data !== 8'h22) begin errors++; $display("FAIL corner_zero got=wr%b addr%0d data%0h exp=wr1 addr0 data22", fb_wr_en, fb_addr, fb_data); end
  endtask

  // x=400 on row 299: clipped, or queued with address 120000 (mod 2^17).
  task automatic test_clip();
    do_reset();
    fb_grant = 1'b1;
    set_pixel(1'b1, 400, 299, 8'h33);
    tick();
    set_pixel(1'b0, 0, 0, 0);
`ifdef FB_CLIP_EN
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL clip_drops got=%0d exp=1", drop_count); end
    checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL clip_overflow got=%b exp=0", overflow); end
    checks++; if (level !== 5'd0)       begin errors++; $display("FAIL clip_level got=%0d exp=0", level); end
    tick();
    checks++; if (fb_wr_en !== 1'b0)    begin errors++; $display("FAIL clip_wr_en got=%b exp=0", fb_wr_en); end
`else
    checks++; if (level !== 5'd1)       begin errors++; $display("FAIL noclip_level got=%0d exp=1", level); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL noclip_drops got=%0d exp=0", drop_count); end
    tick();
    checks++; if (fb_wr_en !== 1'b1 || fb_addr !== 17'd120000 || fb_data !== 8'h33) begin errors++; $display("FAIL noclip_addr got=wr%b addr%0d data%0h exp=wr1 addr120000 data33", fb_wr_en, fb_addr, fb_data); end
`endif
  endtask

  // Reset with 8 entries queued and grant high: everything is discarded.
  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_pixel(1'b1, i, 10, 8'h60 + i);
      tick();
    end
    set_pixel(1'b0, 0, 0, 0);
    checks++; if (level !== 5'd8) begin errors++; $display("FAIL mid_level8 got=%0d exp=8", level); end
    fb_grant = 1'b1;
    reset_n  = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++; if (level !== 5'd0 || fb_wr_en !== 1'b0) begin errors++; $display("FAIL mid_reset got=lvl%0d wr%b exp=lvl0 wr0", level, fb_wr_en); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (fb_wr_en !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL mid_quiet_%0d got=wr%b lvl%0d exp=wr0 lvl0", i, fb_wr_en, level); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_overflow();
    test_back_to_back();
    test_corners();
    test_clip();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
